// File: rtl/intr_pending_latch_if.sv
// intr_pending_latch_if: register-access bus between the controller-side master and the pending latch
interface intr_pending_latch_if;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [15:0] pwdata;
    logic        pready;
    logic [15:0] prdata;
    modport master (output penable, pwrite, paddr, pwdata, input pready, prdata);
    modport slave  (input penable, pwrite, paddr, pwdata, output pready, prdata);
endinterface

// File: rtl/intr_pending_latch.sv
// intr_pending_latch: synchronises raw IRQs, latches them per line as edge/level pending bits, masks them onto intr_active; INTR_SW_TRIG_EN adds the SWTRIG register at 0x4
module intr_pending_latch #(
    parameter int NUM_INTR    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 pclk,
    input  logic                 prst_n,
    input  logic [NUM_INTR-1:0]  irq_raw,
    intr_pending_latch_if.slave  bus,
    output logic [NUM_INTR-1:0]  intr_active,
    input  logic [3:0]           intr_to_service,
    input  logic                 intr_valid,
    input  logic                 intr_serviced
);
    logic [SYNC_STAGES-1:0][NUM_INTR-1:0] sync_q;
    logic [NUM_INTR-1:0] s, prev, mask, mode, pend;
    logic [NUM_INTR-1:0] rise, svc_clr, w1c, sw_set, to_edge, pend_nxt, rdata;
    logic                wr, rd;

    assign s           = sync_q[SYNC_STAGES-1];
    assign intr_active = pend & mask;

    // Next pending state: edge-mode set beats clear; a level->edge switch drops the stale bit
    always_comb begin
        wr       = bus.penable & bus.pwrite;
        rd       = bus.penable & ~bus.pwrite;
        rise     = s & ~prev;
        svc_clr  = (intr_valid & intr_serviced) ? NUM_INTR'(1) << intr_to_service : '0;
        w1c      = (wr && bus.paddr == 4'h2) ? bus.pwdata : '0;
        to_edge  = (wr && bus.paddr == 4'h1) ? bus.pwdata & ~mode : '0;
`ifdef INTR_SW_TRIG_EN
        sw_set   = (wr && bus.paddr == 4'h4) ? bus.pwdata & mode : '0;
`else
        sw_set   = '0;
`endif
        pend_nxt = ((mode & (rise | sw_set | (pend & ~(svc_clr | w1c)))) | (~mode & s)) & ~to_edge;
        rdata    = bus.paddr == 4'h0 ? mask :
                   bus.paddr == 4'h1 ? mode :
                   bus.paddr == 4'h2 ? pend :
                   bus.paddr == 4'h3 ? s    : '0;
    end

    // Synchroniser chain and edge history, tracked in every mode
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            prev   <= s;
        end
    end

    // MASK, MODE and PENDING state
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            mask <= '0;
            mode <= '0;
            pend <= '0;
        end else begin
            mask <= (wr && bus.paddr == 4'h0) ? bus.pwdata : mask;
            mode <= (wr && bus.paddr == 4'h1) ? bus.pwdata : mode;
            pend <= pend_nxt;
        end
    end

    // Bus acknowledge and read data, which holds between reads
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            bus.pready <= 1'b0;
            bus.prdata <= '0;
        end else begin
            bus.pready <= bus.penable;
            bus.prdata <= rd ? rdata : bus.prdata;
        end
    end
endmodule
